// File: rtl/maxpool_stream_ctrl_pkg.sv
// Shared types and sizing helpers for the maxpool stream controller.
package maxpool_stream_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_POOL  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_IMG_W      = 28;
    localparam int DEF_IMG_H      = 28;

    // Counter width able to hold 0..n-1; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int COL_W = cnt_w(DEF_IMG_W);
    localparam int ROW_W = cnt_w(DEF_IMG_H);

endpackage

// File: rtl/maxpool_stream_ctrl_max4.sv
// Combinational 2x2 maxpool unit: unsigned maximum of four pixels.
module maxpool_stream_ctrl_max4 #(
    parameter int DATA_WIDTH = 16
) (
    input  logic [DATA_WIDTH-1:0] in0_i,
    input  logic [DATA_WIDTH-1:0] in1_i,
    input  logic [DATA_WIDTH-1:0] in2_i,
    input  logic [DATA_WIDTH-1:0] in3_i,
    output logic [DATA_WIDTH-1:0] max_o
);

    logic [DATA_WIDTH-1:0] m01;
    logic [DATA_WIDTH-1:0] m23;

    // Two-level compare tree; ties pick either operand, which are equal anyway.
    always_comb begin
        m01   = (in0_i >= in1_i) ? in0_i : in1_i;
        m23   = (in2_i >= in3_i) ? in2_i : in3_i;
        max_o = (m01 >= m23) ? m01 : m23;
    end

endmodule

// File: rtl/maxpool_stream_ctrl.sv
// Streams one raster-ordered feature map through a 2x2 maxpool per start.
// Valid/ready: a transfer happens on a rising edge where valid and ready are
// both high; valid must hold its data until that edge, ready may toggle freely.
// Even rows are packed in pairs into rowbuf; odd rows complete each window.
module maxpool_stream_ctrl
    import maxpool_stream_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int IMG_W      = DEF_IMG_W,
    parameter int IMG_H      = DEF_IMG_H
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done,
    output state_e                dbg_state
);

    localparam int CW   = cnt_w(IMG_W);
    localparam int RW   = cnt_w(IMG_H);
    localparam int HALF = IMG_W / 2;
    localparam int HW   = cnt_w(HALF);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    state_e                  state_q, state_d;
    logic [CW-1:0]           col_q, col_d;
    logic [RW-1:0]           row_q, row_d;
    logic [DATA_WIDTH-1:0]   hold_q;
    logic [DATA_WIDTH-1:0]   out_data_q;
    logic                    out_valid_q;
    logic [2*DATA_WIDTH-1:0] rowbuf_q [HALF];
    logic [2*DATA_WIDTH-1:0] rb_word;
    logic [DATA_WIDTH-1:0]   max_w;
    logic [HW-1:0]           half_col;
    logic                    pool_rdy;
    logic                    in_xfer;
    logic                    last_col;
    logic                    win_load;

    assign last_col  = (col_q == COL_LAST);
    assign half_col  = HW'(col_q >> 1);
    assign rb_word   = rowbuf_q[half_col];
    assign pool_rdy  = !out_valid_q || out_ready;
    assign in_xfer   = in_valid && in_ready;
    assign win_load  = in_xfer && (state_q == ST_POOL) && col_q[0];
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign dbg_state = state_q;

    // Next-state decode plus the per-state stream and status outputs.
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_FILL;
            end
            ST_FILL: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid && last_col) state_d = ST_POOL;
            end
            ST_POOL: begin
                in_ready = pool_rdy;
                busy     = 1'b1;
                if (in_valid && pool_rdy && last_col)
                    state_d = (row_q == ROW_LAST) ? ST_DRAIN : ST_FILL;
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (pool_rdy) state_d = ST_DONE;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Column/row position; both move only when a pixel is accepted.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (in_xfer) begin
            if (last_col) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // State, counters, left-pixel hold and the registered output stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            col_q       <= '0;
            row_q       <= '0;
            hold_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            if (in_xfer && !col_q[0]) hold_q <= in_data;
            if (win_load) begin
                out_data_q  <= max_w;
                out_valid_q <= 1'b1;
            end else if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    // Even-row pixel pairs {left, right}; always written before the odd row reads them.
    always_ff @(posedge clk) begin
        if (in_xfer && (state_q == ST_FILL) && col_q[0])
            rowbuf_q[half_col] <= {hold_q, in_data};
    end

    maxpool_stream_ctrl_max4 #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_max4 (
        .in0_i(rb_word[2*DATA_WIDTH-1:DATA_WIDTH]),
        .in1_i(rb_word[DATA_WIDTH-1:0]),
        .in2_i(hold_q),
        .in3_i(in_data),
        .max_o(max_w)
    );

endmodule

// File: tb/tb_maxpool_stream_ctrl.sv
// Directed bench for maxpool_stream_ctrl: three instances (4x2, 4x4, 28x28).
module tb_maxpool_stream_ctrl;
    import maxpool_stream_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start     [3];
    logic [15:0] in_data   [3];
    logic        in_valid  [3];
    logic        out_ready [3];
    logic        in_ready_w  [3];
    logic [15:0] out_data_w  [3];
    logic        out_valid_w [3];
    logic        busy_w      [3];
    logic        done_w      [3];
    state_e      dbg_w       [3];

    int          total = 0;
    int          bad   = 0;
    int          aborted = 0;
    int          done_cnt [3] = '{0, 0, 0};
    logic [15:0] got_q [$];
    logic [15:0] exp_q [$];
    logic [15:0] pix [784];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int W = (g == 2) ? 28 : 4;
        localparam int H = (g == 0) ? 2 : ((g == 1) ? 4 : 28);
        maxpool_stream_ctrl #(.DATA_WIDTH(16), .IMG_W(W), .IMG_H(H)) u_dut (
            .clk(clk), .rst_n(rst_n), .start(start[g]),
            .in_data(in_data[g]), .in_valid(in_valid[g]), .in_ready(in_ready_w[g]),
            .out_data(out_data_w[g]), .out_valid(out_valid_w[g]), .out_ready(out_ready[g]),
            .busy(busy_w[g]), .done(done_w[g]), .dbg_state(dbg_w[g])
        );
    end

    // Monitor: an output handshake or done seen at the falling edge completes on the next rising edge.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (done_w[k]) done_cnt[k]++;
            if (out_valid_w[k] && out_ready[k]) got_q.push_back(out_data_w[k]);
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Offer one pixel and hold it until accepted (bounded wait).
    task automatic drive_pixel(input int k, input logic [15:0] d);
        int waited;
        waited = 0;
        if (aborted != 0) return;
        in_valid[k] = 1'b1;
        in_data[k]  = d;
        forever begin
            @(negedge clk);
            if (in_ready_w[k] || waited > 200) break;
            waited++;
        end
        chk("in_accept", in_ready_w[k], 1'b1);
        if (!in_ready_w[k]) aborted = 1;
        @(posedge clk);
        #1;
        in_valid[k] = 1'b0;
    endtask

    task automatic pulse_start(input int k);
        start[k] = 1'b1;
        step(1);
        start[k] = 1'b0;
    endtask

    task automatic wait_done(input int k, input int limit);
        int n;
        n = 0;
        while (!done_w[k] && n < limit) begin
            step(1);
            n++;
        end
        chk("done_seen", done_w[k], 1'b1);
        step(1);
        chk("done_pulse_len", done_w[k], 1'b0);
        chk("idle_after_done", 32'(dbg_w[k]), 32'(ST_IDLE));
        chk("busy_after_done", busy_w[k], 1'b0);
    endtask

    task automatic check_outputs(input string tag, input int base);
        chk({tag, "_count"}, got_q.size() - base, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (base + i < got_q.size()) chk({tag, "_data"}, got_q[base + i], exp_q[i]);
    endtask

    initial begin
        int base;
        int dbase;
        logic [15:0] a, b, c, d, m;

        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            start[k] = 1'b0; in_data[k] = '0; in_valid[k] = 1'b0; out_ready[k] = 1'b0;
        end
        step(3);
        for (int k = 0; k < 3; k++) begin
            chk("rst_state", 32'(dbg_w[k]), 32'(ST_IDLE));
            chk("rst_in_ready", in_ready_w[k], 1'b0);
            chk("rst_out_valid", out_valid_w[k], 1'b0);
            chk("rst_out_data", out_data_w[k], 16'h0);
            chk("rst_busy", busy_w[k], 1'b0);
            chk("rst_done", done_w[k], 1'b0);
        end
        rst_n = 1'b1;
        step(2);

        // 4x2 frame, downstream always ready: 5 then 9.
        out_ready[0] = 1'b1;
        base = got_q.size(); dbase = done_cnt[0];
        exp_q = '{16'd5, 16'd9};
        pulse_start(0);
        chk("t1_state_fill", 32'(dbg_w[0]), 32'(ST_FILL));
        chk("t1_busy", busy_w[0], 1'b1);
        chk("t1_in_ready_fill", in_ready_w[0], 1'b1);
        drive_pixel(0, 16'd1); drive_pixel(0, 16'd5); drive_pixel(0, 16'd2); drive_pixel(0, 16'd3);
        chk("t1_state_pool", 32'(dbg_w[0]), 32'(ST_POOL));
        drive_pixel(0, 16'd4); drive_pixel(0, 16'd0);
        chk("t1_lat_valid", out_valid_w[0], 1'b1);
        chk("t1_lat_data", out_data_w[0], 16'd5);
        drive_pixel(0, 16'd9); drive_pixel(0, 16'd7);
        chk("t1_state_drain", 32'(dbg_w[0]), 32'(ST_DRAIN));
        chk("t1_last_data", out_data_w[0], 16'd9);
        chk("t1_in_ready_drain", in_ready_w[0], 1'b0);
        wait_done(0, 20);
        check_outputs("t1", base);
        chk("t1_done_once", done_cnt[0] - dbase, 1);

        // 4x4 frame with a downstream stall in row 1 and a start pulse mid-frame.
        out_ready[1] = 1'b1;
        base = got_q.size(); dbase = done_cnt[1];
        exp_q = '{16'd5, 16'd9, 16'hFFFF, 16'd8};
        pulse_start(1);
        drive_pixel(1, 16'd1); drive_pixel(1, 16'd5); drive_pixel(1, 16'd2); drive_pixel(1, 16'd3);
        out_ready[1] = 1'b0;
        drive_pixel(1, 16'd4); drive_pixel(1, 16'd0);
        chk("t2_valid", out_valid_w[1], 1'b1);
        chk("t2_data", out_data_w[1], 16'd5);
        chk("t2_in_ready_stall", in_ready_w[1], 1'b0);
        in_valid[1] = 1'b1; in_data[1] = 16'd9;
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk("t2_hold_data", out_data_w[1], 16'd5);
            chk("t2_hold_valid", out_valid_w[1], 1'b1);
            chk("t2_hold_in_ready", in_ready_w[1], 1'b0);
        end
        chk("t2_no_early_out", got_q.size() - base, 0);
        out_ready[1] = 1'b1;
        drive_pixel(1, 16'd9); drive_pixel(1, 16'd7);
        drive_pixel(1, 16'hFFFF);
        pulse_start(1);
        chk("t2_start_ignored_state", 32'(dbg_w[1]), 32'(ST_FILL));
        chk("t2_start_ignored_busy", busy_w[1], 1'b1);
        drive_pixel(1, 16'h0001); drive_pixel(1, 16'd6); drive_pixel(1, 16'd2);
        drive_pixel(1, 16'h8000); drive_pixel(1, 16'h7FFF);
        chk("t2_unsigned_max", out_data_w[1], 16'hFFFF);
        drive_pixel(1, 16'd1); drive_pixel(1, 16'd8);
        wait_done(1, 20);
        check_outputs("t2", base);
        chk("t2_done_once", done_cnt[1] - dbase, 1);

        // Reset during row 1 of a 4x2 frame, then a clean frame with new data.
        out_ready[0] = 1'b0;
        pulse_start(0);
        drive_pixel(0, 16'd1); drive_pixel(0, 16'd5); drive_pixel(0, 16'd2); drive_pixel(0, 16'd3);
        drive_pixel(0, 16'd4); drive_pixel(0, 16'd0);
        chk("t3_pre_valid", out_valid_w[0], 1'b1);
        rst_n = 1'b0;
        #1;
        chk("t3_rst_valid", out_valid_w[0], 1'b0);
        chk("t3_rst_busy", busy_w[0], 1'b0);
        chk("t3_rst_state", 32'(dbg_w[0]), 32'(ST_IDLE));
        step(2);
        rst_n = 1'b1;
        step(1);
        out_ready[0] = 1'b1;
        base = got_q.size(); dbase = done_cnt[0];
        exp_q = '{16'd7, 16'd10};
        pulse_start(0);
        drive_pixel(0, 16'd7); drive_pixel(0, 16'd2); drive_pixel(0, 16'd3); drive_pixel(0, 16'd3);
        drive_pixel(0, 16'd1); drive_pixel(0, 16'd1); drive_pixel(0, 16'd0); drive_pixel(0, 16'd10);
        wait_done(0, 20);
        check_outputs("t3", base);
        chk("t3_done_once", done_cnt[0] - dbase, 1);

        // 28x28 frame with random input gaps and random downstream back-pressure.
        for (int i = 0; i < 784; i++) pix[i] = 16'($urandom_range(0, 65535));
        exp_q.delete();
        for (int r = 0; r < 14; r++)
            for (int cc = 0; cc < 14; cc++) begin
                a = pix[(2*r)*28 + 2*cc];     b = pix[(2*r)*28 + 2*cc + 1];
                c = pix[(2*r+1)*28 + 2*cc];   d = pix[(2*r+1)*28 + 2*cc + 1];
                m = a;
                if (b > m) m = b;
                if (c > m) m = c;
                if (d > m) m = d;
                exp_q.push_back(m);
            end
        out_ready[2] = 1'b1;
        base = got_q.size(); dbase = done_cnt[2];
        pulse_start(2);
        fork
            begin
                for (int i = 0; i < 784; i++) begin
                    repeat ($urandom_range(0, 2)) step(1);
                    drive_pixel(2, pix[i]);
                end
            end
            begin
                int lim;
                lim = 0;
                while (done_cnt[2] == dbase && lim < 20000) begin
                    step(1);
                    out_ready[2] = ($urandom_range(0, 3) != 0);
                    lim++;
                end
                out_ready[2] = 1'b1;
            end
        join
        step(5);
        check_outputs("t4", base);
        chk("t4_done_once", done_cnt[2] - dbase, 1);
        chk("t4_idle", 32'(dbg_w[2]), 32'(ST_IDLE));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
